tdm_demux: RTL and testbench

Time-division demultiplexer: the receive end of the team's N-to-1 TDM multiplexer link. It takes a framed, beat-serial stream of W-bit words and deals slot k of each frame onto output channel k, with a per-channel strobe, a frame-complete pulse and framing-error detection. It sits between the serial link and the per-channel consumers, which previously received a pre-split bus.

---
 rtl/tdm_pkg.sv | 21 ++
 rtl/tdm_slot_ctr.sv | 28 ++
 rtl/tdm_demux.sv | 81 ++++++++
 tb/tb_tdm_demux.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link: frame state encoding, default geometry,
// and the slot-index width helper used by both the mux and the demux.
package tdm_pkg;

   localparam int TDM_N = 4;
   localparam int TDM_W = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } tdm_state_e;

   // Never returns less than 1, so the slot index is always at least one bit wide.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Modulo-N slot counter. A load0 beat counts as slot 0, so the next expected slot is 1.
module tdm_slot_ctr
   import tdm_pkg::*;
#(
   parameter int N  = TDM_N,
   parameter int SW = clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          load0,
   output logic [SW-1:0] slot,
   output logic          last
);

   assign last = (slot == SW'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot <= '0;
      end else if (en) begin
         if (load0)     slot <= SW'(1);
         else if (last) slot <= '0;
         else           slot <= slot + SW'(1);
      end
   end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive end: deals slot k of each framed beat-serial stream onto channel k,
// with per-channel strobes, frame-complete pulse and framing-error detection.
//
// state | meaning
// IDLE  | waiting for an SOF beat; non-SOF beats are dropped
// RUN   | frame in progress, slot counter holds the next expected slot
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int N = TDM_N,
   parameter int W = TDM_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [W-1:0]   in_data,
   input  logic           in_valid,
   input  logic           in_sof,
   output logic [N*W-1:0] out_data,
   output logic [N-1:0]   out_valid,
   output logic           frame_done,
   output logic           frame_err,
   output logic [7:0]     err_cnt
);

   localparam int SW = clog2(N);
   localparam logic [0:0] S_IDLE = IDLE;
   localparam logic [0:0] S_RUN  = RUN;

   logic [0:0]    state;
   logic [SW-1:0] slot;
   logic          last;
   logic          sof;
   logic          capture;
   logic          done_nxt;
   logic          err_nxt;
   logic [SW-1:0] idx;

   assign sof      = in_valid & in_sof;
   assign capture  = sof | (in_valid & (state == S_RUN));
   assign done_nxt = in_valid & ~in_sof & (state == S_RUN) & last;
   assign err_nxt  = sof & (state == S_RUN);
   assign idx      = in_sof ? '0 : slot;

   tdm_slot_ctr #(.N(N), .SW(SW)) u_slot_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (capture),
      .load0 (in_sof),
      .slot  (slot),
      .last  (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else if (sof) begin
         state <= S_RUN;
      end else if (done_nxt) begin
         state <= S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data   <= '0;
         out_valid  <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         err_cnt    <= '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            out_valid[k] <= capture && (idx == SW'(k));
            if (capture && (idx == SW'(k))) out_data[k*W +: W] <= in_data;
         end
         frame_done <= done_nxt;
         frame_err  <= err_nxt;
         if (err_nxt && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (N=4, W=4): framing, stalls, resync, saturation, async reset.
module tb_tdm_demux;

   logic        clk;
   logic        rst_n;
   logic [3:0]  in_data;
   logic        in_valid;
   logic        in_sof;
   logic [15:0] out_data;
   logic [3:0]  out_valid;
   logic        frame_done;
   logic        frame_err;
   logic [7:0]  err_cnt;

   int total = 0;
   int bad   = 0;
   int n_done;
   int n_err;

   tdm_demux #(.N(4), .W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_sof     (in_sof),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .err_cnt    (err_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle from a negedge; on return the outputs for that beat are visible.
   task automatic step(input logic v, input logic s, input logic [3:0] d);
      in_valid = v;
      in_sof   = s;
      in_data  = d;
      @(negedge clk);
   endtask

   task automatic chk_out(input string tag, input logic [15:0] d, input logic [3:0] v,
                          input logic dn, input logic er);
      chk({tag, ".data"},  32'(out_data),   32'(d));
      chk({tag, ".valid"}, 32'(out_valid),  32'(v));
      chk({tag, ".done"},  32'(frame_done), 32'(dn));
      chk({tag, ".err"},   32'(frame_err),  32'(er));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_data  = 4'h0;
      repeat (2) @(negedge clk);
      chk_out("reset", 16'h0000, 4'b0000, 1'b0, 1'b0);
      chk("reset.cnt", 32'(err_cnt), 32'd0);
      rst_n = 1'b1;

      // orphan data from reset
      step(1, 0, 4'hA); chk_out("orph0", 16'h0000, 4'b0000, 1'b0, 1'b0);
      step(1, 0, 4'hB); chk_out("orph1", 16'h0000, 4'b0000, 1'b0, 1'b0);
      chk("orph.cnt", 32'(err_cnt), 32'd0);

      // clean frame
      step(1, 1, 4'h1); chk_out("clean0", 16'h0001, 4'b0001, 1'b0, 1'b0);
      step(1, 0, 4'h2); chk_out("clean1", 16'h0021, 4'b0010, 1'b0, 1'b0);
      step(1, 0, 4'h3); chk_out("clean2", 16'h0321, 4'b0100, 1'b0, 1'b0);
      step(1, 0, 4'h4); chk_out("clean3", 16'h4321, 4'b1000, 1'b1, 1'b0);
      step(0, 0, 4'h0); chk_out("clean_idle", 16'h4321, 4'b0000, 1'b0, 1'b0);

      // same frame with two stall cycles between beats
      do_reset();
      chk("stall.rst", 32'(out_data), 32'h0);
      step(1, 1, 4'h1); chk_out("stall0", 16'h0001, 4'b0001, 1'b0, 1'b0);
      step(0, 1, 4'hF); chk_out("stall0a", 16'h0001, 4'b0000, 1'b0, 1'b0);
      step(0, 0, 4'hE); chk_out("stall0b", 16'h0001, 4'b0000, 1'b0, 1'b0);
      step(1, 0, 4'h2); chk_out("stall1", 16'h0021, 4'b0010, 1'b0, 1'b0);
      step(0, 0, 4'hD); step(0, 0, 4'hD);
      chk_out("stall1b", 16'h0021, 4'b0000, 1'b0, 1'b0);
      step(1, 0, 4'h3); chk_out("stall2", 16'h0321, 4'b0100, 1'b0, 1'b0);
      step(0, 0, 4'hC); step(0, 0, 4'hC);
      chk_out("stall2b", 16'h0321, 4'b0000, 1'b0, 1'b0);
      step(1, 0, 4'h4); chk_out("stall3", 16'h4321, 4'b1000, 1'b1, 1'b0);
      step(0, 0, 4'h0); chk_out("stall_end", 16'h4321, 4'b0000, 1'b0, 1'b0);

      // premature SOF
      step(1, 1, 4'h1); chk_out("pre0", 16'h4321, 4'b0001, 1'b0, 1'b0);
      step(1, 0, 4'h2); chk_out("pre1", 16'h4321, 4'b0010, 1'b0, 1'b0);
      step(1, 1, 4'h5); chk_out("pre_sof", 16'h4325, 4'b0001, 1'b0, 1'b1);
      chk("pre.cnt", 32'(err_cnt), 32'd1);
      step(1, 0, 4'h6); chk_out("pre6", 16'h4365, 4'b0010, 1'b0, 1'b0);
      step(1, 0, 4'h7); chk_out("pre7", 16'h4765, 4'b0100, 1'b0, 1'b0);
      step(1, 0, 4'h8); chk_out("pre8", 16'h8765, 4'b1000, 1'b1, 1'b0);
      chk("pre.cnt_end", 32'(err_cnt), 32'd1);

      // two contiguous frames
      n_done = 0;
      n_err  = 0;
      for (int i = 0; i < 8; i++) begin
         step(1, (i % 4) == 0, 4'(i + 1));
         n_done += int'(frame_done);
         n_err  += int'(frame_err);
      end
      chk("b2b.done", 32'(n_done), 32'd2);
      chk("b2b.err", 32'(n_err), 32'd0);
      chk("b2b.data", 32'(out_data), 32'h8765);
      chk("b2b.cnt", 32'(err_cnt), 32'd1);

      // 300 SOFs: the first opens a frame, the other 299 are premature
      n_err = 0;
      for (int i = 0; i < 300; i++) begin
         step(1, 1, 4'(i));
         n_err += int'(frame_err);
         if (i == 9) chk("sat.cnt10", 32'(err_cnt), 32'd10);
      end
      chk("sat.pulses", 32'(n_err), 32'd299);
      chk("sat.cnt", 32'(err_cnt), 32'd255);
      step(0, 0, 4'h0);
      chk("sat.hold", 32'(err_cnt), 32'd255);

      // reset mid-frame, asserted between clock edges
      do_reset();
      step(1, 1, 4'h1); chk_out("mid0", 16'h0001, 4'b0001, 1'b0, 1'b0);
      step(1, 0, 4'h2); chk_out("mid1", 16'h0021, 4'b0010, 1'b0, 1'b0);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk_out("mid_rst", 16'h0000, 4'b0000, 1'b0, 1'b0);
      chk("mid_rst.cnt", 32'(err_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 4'h3); chk_out("mid_orph", 16'h0000, 4'b0000, 1'b0, 1'b0);
      step(1, 1, 4'h9);
      step(1, 0, 4'hA);
      step(1, 0, 4'hB);
      step(1, 0, 4'hC); chk_out("mid_frame", 16'hCBA9, 4'b1000, 1'b1, 1'b0);
      chk("mid.cnt", 32'(err_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
